als_sample_sched: RTL

ALS_SAMPLE_SCHED -- requirements
Module: als_sample_sched

---
 rtl/als_sample_sched.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/als_sample_sched.sv
// Ambient-light sample scheduler: periodic/software requests -> SPI read -> 8-bit sample -> optional UART byte.
// Latency: request -> spi_start_o 1 cycle later; spi_done_i -> sample_valid_o 1 cycle later.
// Backpressure: uart_valid_o holds until uart_ready_i; requests during a transaction queue one deep, extras count as overruns.
module als_sample_sched #(
  parameter int unsigned SAMPLE_PERIOD = 1000000,
  parameter int unsigned TIMEOUT_CYC   = 4096
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        trig_i,
  input  logic        uart_en_i,
  input  logic        clr_err_i,
  output logic        spi_start_o,
  input  logic        spi_busy_i,
  input  logic        spi_done_i,
  input  logic [15:0] spi_rx_i,
  output logic [7:0]  sample_o,
  output logic        sample_valid_o,
  output logic [7:0]  uart_data_o,
  output logic        uart_valid_o,
  input  logic        uart_ready_i,
  output logic        err_timeout_o,
  output logic [7:0]  ovr_cnt_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    EXTRACT   = 3'd3,
    UART_SEND = 3'd4
  } state_t;

  localparam logic [31:0] PERIOD_LAST  = 32'(SAMPLE_PERIOD - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_d;
  logic [31:0] period_cnt;
  logic [15:0] tmo_cnt;
  logic        pending;
  logic        tick;
  logic        req;
  logic        overrun;
  logic        take_req;
  logic        tmo_clr;
  logic        tmo_inc;
  logic        timeout;
  logic        capture;
  logic        load_uart;

  // Frame layout: 3 leading zeros, 8 data bits, 5 trailing bits; only [12:5] carries the sample.
  logic unused_rx_bits;
  assign unused_rx_bits = ^{spi_rx_i[15:13], spi_rx_i[4:0]};

  assign tick    = en_i && (period_cnt == PERIOD_LAST);
  assign req     = tick || trig_i;
  assign overrun = req && pending;

  // Control outputs are pure decodes of the state register.
  assign spi_start_o  = (state == START);
  assign uart_valid_o = (state == UART_SEND);
  assign busy_o       = (state != IDLE);

  // State register.
  always_ff @(posedge i_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d   = state;
    take_req  = 1'b0;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    timeout   = 1'b0;
    capture   = 1'b0;
    load_uart = 1'b0;
    case (state)
      IDLE: begin
        if ((req || pending) && !spi_busy_i) begin
          state_d  = START;
          take_req = 1'b1;
        end
      end
      START: begin
        state_d = WAIT_DONE;
        tmo_clr = 1'b1;
      end
      WAIT_DONE: begin
        if (spi_done_i) begin
          state_d = EXTRACT;
          capture = 1'b1;
        end else if (tmo_cnt == TIMEOUT_LAST) begin
          state_d = IDLE;
          timeout = 1'b1;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      EXTRACT: begin
        if (uart_en_i) begin
          state_d   = UART_SEND;
          load_uart = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      UART_SEND: begin
        if (uart_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Period counter: held at zero while disabled, wraps after the tick.
  always_ff @(posedge i_clk) begin
    if (rst || !en_i || tick) period_cnt <= '0;
    else                      period_cnt <= period_cnt + 32'd1;
  end

  // SPI response timeout counter, restarted for every frame.
  always_ff @(posedge i_clk) begin
    if (rst || tmo_clr) tmo_cnt <= '0;
    else if (tmo_inc)   tmo_cnt <= tmo_cnt + 16'd1;
  end

  // One-deep request queue; IDLE consuming it wins over a coincident new request.
  always_ff @(posedge i_clk) begin
    if (rst || take_req) pending <= 1'b0;
    else if (req)        pending <= 1'b1;
  end

  // Sample capture happens on the done edge so spi_rx_i is taken while it is valid.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      uart_data_o    <= '0;
    end else begin
      sample_valid_o <= capture;
      if (capture)   sample_o    <= spi_rx_i[12:5];
      if (load_uart) uart_data_o <= sample_o;
    end
  end

  // Sticky error and overrun counter; set/increment beats a same-cycle clear.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      err_timeout_o <= 1'b0;
      ovr_cnt_o     <= '0;
    end else begin
      if (timeout)        err_timeout_o <= 1'b1;
      else if (clr_err_i) err_timeout_o <= 1'b0;
      if (overrun) begin
        if (ovr_cnt_o != 8'hFF) ovr_cnt_o <= ovr_cnt_o + 8'd1;
      end else if (clr_err_i) begin
        ovr_cnt_o <= '0;
      end
    end
  end

endmodule
